// File: rtl/mod_n_up_counter_pkg.sv
// Shared definitions for the modulo-N up counter: run-control state encoding.
// The encoding matches the down-counter family so state probes read the same.
package mod_n_up_counter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/mod_n_up_counter_core.sv
// BIT-wide count register with load/clear/increment controls and async reset.
// Control priority is load, then clear, then increment; otherwise the count holds.
module mod_n_up_counter_core #(
   parameter int BIT = 4
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           clr_i,
   input  logic           ld_i,
   input  logic [BIT-1:0] ld_val_i,
   input  logic           inc_i,
   output logic [BIT-1:0] count_o
);

   logic [BIT-1:0] count_q;
   logic [BIT-1:0] count_d;

   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      count_d = count_q;
      if (ld_i) begin
         count_d = ld_val_i;
      end else if (clr_i) begin
         count_d = '0;
      end else if (inc_i) begin
         count_d = count_q + BIT'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/mod_n_up_counter.sv
// Programmable modulo-N up counter: run-control FSM, terminal compare and tc register.
// Continuous mode wraps and pulses tc; one-shot mode parks at max_val in DONE.
module mod_n_up_counter
   import mod_n_up_counter_pkg::*;
#(
   parameter int BIT = 4
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           start,
   input  logic           stop,
   input  logic           oneshot,
   input  logic           load,
   input  logic [BIT-1:0] load_val,
   input  logic [BIT-1:0] max_val,
   output logic [BIT-1:0] count,
   output logic           tc,
   output logic           busy,
   output logic           done
);

   state_e         state_q;
   state_e         state_d;
   logic           tc_q;
   logic           tc_d;
   logic           clr;
   logic           inc;
   logic           term;
   logic [BIT-1:0] load_clamped;

   // >= rather than == so a lowered max_val never lets the count run out of range.
   assign term         = (count >= max_val);
   assign load_clamped = (load_val > max_val) ? max_val : load_val;

   always_comb begin
      state_d = state_q;
      tc_d    = 1'b0;
      clr     = 1'b0;
      inc     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start && !stop) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (!load) begin
               // A load edge replaces the count action, so no terminal event on it.
               if (term) begin
                  tc_d = 1'b1;
                  if (oneshot) state_d = ST_DONE;
                  else         clr     = 1'b1;
               end else begin
                  inc = 1'b1;
               end
            end
         end
         ST_DONE: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (start) begin
               state_d = ST_RUN;
               clr     = !load;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         tc_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         tc_q    <= tc_d;
      end
   end

   mod_n_up_counter_core #(.BIT(BIT)) u_core (
      .clk      (clk),
      .reset_n  (reset_n),
      .clr_i    (clr),
      .ld_i     (load),
      .ld_val_i (load_clamped),
      .inc_i    (inc),
      .count_o  (count)
   );

   assign tc   = tc_q;
   assign busy = (state_q == ST_RUN);
   assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_mod_n_up_counter.sv
// Directed bench for mod_n_up_counter: a reference model queues expected outputs per edge,
// which are popped and compared one half-cycle later.
module tb_mod_n_up_counter;

   localparam int BIT = 4;
   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_DONE = 2;

   typedef struct packed {
      logic [BIT-1:0] count;
      logic           tc;
      logic           busy;
      logic           done;
   } exp_t;

   logic           clk = 1'b0;
   logic           reset_n;
   logic           start;
   logic           stop;
   logic           oneshot;
   logic           load;
   logic [BIT-1:0] load_val;
   logic [BIT-1:0] max_val;
   logic [BIT-1:0] count;
   logic           tc;
   logic           busy;
   logic           done;

   int   vectors    = 0;
   int   miscompares = 0;
   int   step_no    = 0;
   exp_t sb[$];

   int             m_st;
   logic [BIT-1:0] m_cnt;
   logic           m_tc;

   mod_n_up_counter #(.BIT(BIT)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .stop     (stop),
      .oneshot  (oneshot),
      .load     (load),
      .load_val (load_val),
      .max_val  (max_val),
      .count    (count),
      .tc       (tc),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [BIT-1:0] obs, input logic [BIT-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s step %0d: observed %0d expected %0d", tag, step_no, obs, exp);
      end
   endtask

   function automatic exp_t model_out();
      exp_t e;
      e.count = m_cnt;
      e.tc    = m_tc;
      e.busy  = (m_st == M_RUN);
      e.done  = (m_st == M_DONE);
      return e;
   endfunction

   task automatic compare_outputs(input exp_t e);
      check("count", count, e.count);
      check("tc",    {3'b000, tc},   {3'b000, e.tc});
      check("busy",  {3'b000, busy}, {3'b000, e.busy});
      check("done",  {3'b000, done}, {3'b000, e.done});
   endtask

   // One clock edge: drive inputs, advance the reference model, queue its prediction, then compare.
   task automatic step(input logic st, input logic sp, input logic os, input logic ld,
                       input logic [BIT-1:0] lv, input logic [BIT-1:0] mx);
      int             nst;
      logic [BIT-1:0] ncnt;
      logic           ntc;
      exp_t           e;
      @(negedge clk);
      start = st; stop = sp; oneshot = os; load = ld; load_val = lv; max_val = mx;
      nst  = m_st;
      ncnt = m_cnt;
      ntc  = 1'b0;
      if (ld) ncnt = (lv > mx) ? mx : lv;
      if (m_st == M_IDLE) begin
         if (st && !sp) nst = M_RUN;
      end else if (m_st == M_RUN) begin
         if (sp) nst = M_IDLE;
         else if (!ld) begin
            if (m_cnt >= mx) begin
               ntc = 1'b1;
               if (os) nst = M_DONE;
               else    ncnt = '0;
            end else begin
               ncnt = m_cnt + 4'd1;
            end
         end
      end else begin
         if (sp) nst = M_IDLE;
         else if (st) begin
            nst = M_RUN;
            if (!ld) ncnt = '0;
         end
      end
      m_st = nst; m_cnt = ncnt; m_tc = ntc;
      sb.push_back(model_out());
      @(posedge clk);
      #1;
      step_no++;
      e = sb.pop_front();
      compare_outputs(e);
   endtask

   task automatic model_reset();
      m_st = M_IDLE; m_cnt = '0; m_tc = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; stop = 1'b0; oneshot = 1'b0;
      load = 1'b0; load_val = '0; max_val = 4'd9;
      model_reset();
      #1;
      compare_outputs(model_out());
      @(negedge clk);
      reset_n = 1'b1;

      // Continuous, max 9, start held: two full wraps then stop.
      for (int i = 0; i < 23; i++) step(1, 0, 0, 0, 4'd0, 4'd9);
      step(0, 1, 0, 0, 4'd0, 4'd9);

      // One-shot, max 5: clear via load while idle, pulse start, park in DONE, restart.
      step(0, 1, 1, 1, 4'd0, 4'd5);
      step(1, 0, 1, 0, 4'd0, 4'd5);
      for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 4'd0, 4'd5);
      step(1, 0, 1, 0, 4'd0, 4'd5);
      for (int i = 0; i < 2; i++) step(0, 0, 1, 0, 4'd0, 4'd5);
      step(0, 1, 1, 0, 4'd0, 4'd5);

      // Load above max in RUN clamps to max with no tc, then wraps with tc.
      step(1, 0, 0, 0, 4'd0, 4'd9);
      for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 4'd0, 4'd9);
      step(0, 0, 0, 1, 4'd12, 4'd9);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 4'd0, 4'd9);
      step(0, 1, 0, 0, 4'd0, 4'd9);

      // start and stop together stay idle; load with start enters RUN at load_val.
      step(1, 1, 0, 0, 4'd0, 4'd9);
      step(1, 0, 0, 1, 4'd3, 4'd9);
      step(0, 1, 0, 0, 4'd0, 4'd9);

      // Async reset at count 7 mid-RUN, checked before any edge.
      step(0, 1, 0, 1, 4'd0, 4'd9);
      step(1, 0, 0, 0, 4'd0, 4'd9);
      for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 4'd0, 4'd9);
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      compare_outputs(model_out());
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 4'd0, 4'd9);

      // max 0 continuous: tc every RUN edge; then lower max 9 -> 3 at count 6.
      step(1, 0, 0, 0, 4'd0, 4'd0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 4'd0, 4'd0);
      step(0, 0, 0, 1, 4'd6, 4'd9);
      step(0, 0, 0, 0, 4'd0, 4'd3);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 4'd0, 4'd3);

      // max 0 one-shot: DONE after one RUN edge, stop returns to IDLE.
      step(0, 0, 1, 0, 4'd0, 4'd0);
      step(0, 0, 1, 0, 4'd0, 4'd0);
      step(0, 1, 1, 0, 4'd0, 4'd0);
      step(1, 0, 1, 0, 4'd0, 4'd0);
      step(0, 0, 1, 0, 4'd0, 4'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
